// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment driver: glyph constants,
// converter state encoding and small constant helpers.
package seg7_pkg;

  // Active-high glyphs, bit0..6 = segments a..g.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    CNV_IDLE   = 2'd0,
    CNV_SHIFT  = 2'd1,
    CNV_COMMIT = 2'd2
  } cnv_state_e;

  function automatic logic [6:0] seg7_encode(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = SEG_0;
      4'd1:    g = SEG_1;
      4'd2:    g = SEG_2;
      4'd3:    g = SEG_3;
      4'd4:    g = SEG_4;
      4'd5:    g = SEG_5;
      4'd6:    g = SEG_6;
      4'd7:    g = SEG_7;
      4'd8:    g = SEG_8;
      4'd9:    g = SEG_9;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

  // Decimal digits needed to represent 2^width-1.
  function automatic int bcd_digits_for(input int width);
    logic [63:0] m;
    int d;
    m = (64'd1 << width) - 64'd1;
    d = 1;
    while (m >= 64'd10) begin
      m = m / 64'd10;
      d = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Value-load port of the 7-segment driver, plus the converter state for observation.
interface seg7_scan_driver_if #(
  parameter int BIN_WIDTH = 14
);
  import seg7_pkg::*;

  // Handshake: value_in is taken on a rising clock edge where load && ready.
  // load while ready=0 is dropped (no queuing); value_in only matters with load.
  logic [BIN_WIDTH-1:0] value_in;
  logic                 load;
  logic                 ready;
  cnv_state_e           conv_state;

  modport master (output value_in, output load, input ready, input conv_state);
  modport slave  (input value_in, input load, output ready, output conv_state);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one bit per cycle,
// result presented together with a one-cycle done strobe.
module bin2bcd_seq import seg7_pkg::*; #(
  parameter int BIN_WIDTH  = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [BIN_WIDTH-1:0]    value_in,
  input  logic                    load,
  output logic                    ready,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    overflow,
  output cnv_state_e              state_o
);
  localparam int BCD_DIGITS = bcd_digits_for(BIN_WIDTH);
  localparam int SCR_DIGITS = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
  localparam int CNT_W      = $clog2(BIN_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_WIDTH - 1);

  cnv_state_e              state_q, state_d;
  logic [BIN_WIDTH-1:0]    bin_q, bin_d;
  logic [4*SCR_DIGITS-1:0] bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < SCR_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CNV_IDLE: begin
        if (load) begin
          bin_d   = value_in;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CNV_SHIFT;
        end
      end
      CNV_SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == LAST_SHIFT) state_d = CNV_COMMIT;
      end
      CNV_COMMIT: state_d = CNV_IDLE;
      default:    state_d = CNV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CNV_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  // Anything in the nibbles beyond the displayed digits cannot be shown.
  always_comb begin
    overflow = 1'b0;
    for (int i = NUM_DIGITS; i < SCR_DIGITS; i++) begin
      overflow = overflow | (|bcd_q[4*i +: 4]);
    end
  end

  assign bcd_out = bcd_q[4*NUM_DIGITS-1:0];
  assign ready   = (state_q == CNV_IDLE);
  assign done    = (state_q == CNV_COMMIT);
  assign state_o = state_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment driver: sequential BCD conversion, slot scanning
// with blanking, leading-zero suppression, decimal points and overflow dashes.
module seg7_scan_driver import seg7_pkg::*; #(
  parameter int NUM_DIGITS     = 4,
  parameter int BIN_WIDTH      = 14,
  parameter int REFRESH_DIV    = 16000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  seg7_scan_driver_if.slave     bus,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic                  blank_lz,
  output logic [7:0]            seg_out,
  output logic [NUM_DIGITS-1:0] dig_out,
  output logic                  overflow
);
  localparam int SLOT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SLOT_W-1:0]     SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0]     SLOT_BLNK = SLOT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF   = DIG_ACTIVE_LOW ? '1 : '0;

  logic                    cnv_done, cnv_ovf;
  logic [4*NUM_DIGITS-1:0] cnv_bcd;

  bin2bcd_seq #(
    .BIN_WIDTH  (BIN_WIDTH),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk      (CLK),
    .rst_n    (RST_N),
    .value_in (bus.value_in),
    .load     (bus.load),
    .ready    (bus.ready),
    .done     (cnv_done),
    .bcd_out  (cnv_bcd),
    .overflow (cnv_ovf),
    .state_o  (bus.conv_state)
  );

  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] display_q, display_d;
  logic                    overflow_q, overflow_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;

  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    nz_above;
  logic                    suppress, cur_dp;
  logic [6:0]              glyph;
  logic [7:0]              seg_act;
  logic [NUM_DIGITS-1:0]   dig_act;

  // The display register only ever changes on the converter's commit cycle.
  assign display_d  = cnv_done ? cnv_bcd : display_q;
  assign overflow_d = cnv_done ? cnv_ovf : overflow_q;

  always_comb begin
    slot_d = slot_q;
    idx_d  = idx_q;
    if (slot_q == SLOT_LAST) begin
      slot_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      slot_d = slot_q + 1'b1;
    end
  end

  // lz_mask[i] is set when digit i and everything above it are zero; digit 0 never.
  always_comb begin
    nz_above = 1'b0;
    lz_mask  = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      nz_above   = nz_above | (display_q[4*i +: 4] != 4'd0);
      lz_mask[i] = ~nz_above;
    end
  end

  always_comb begin
    cur_dp   = dp_in[idx_q];
    suppress = blank_lz & ~overflow_q & lz_mask[idx_q];
    glyph    = overflow_q ? SEG_DASH
             : (suppress ? SEG_BLANK : seg7_encode(display_q[4*idx_q +: 4]));
    seg_act  = 8'h00;
    dig_act  = '0;
    if (slot_q >= SLOT_BLNK) begin
      seg_act = {cur_dp, glyph};
      if (!suppress || cur_dp) dig_act = NUM_DIGITS'(1) << idx_q;
    end
    seg_d = SEG_ACTIVE_LOW ? ~seg_act : seg_act;
    dig_d = DIG_ACTIVE_LOW ? ~dig_act : dig_act;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      slot_q     <= '0;
      idx_q      <= '0;
      display_q  <= '0;
      overflow_q <= 1'b0;
      seg_q      <= SEG_OFF;
      dig_q      <= DIG_OFF;
    end else begin
      slot_q     <= slot_d;
      idx_q      <= idx_d;
      display_q  <= display_d;
      overflow_q <= overflow_d;
      seg_q      <= seg_d;
      dig_q      <= dig_d;
    end
  end

  assign seg_out  = seg_q;
  assign dig_out  = dig_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed steps plus random loads, every cycle compared
// against an arithmetic model of what the display should show.
module tb_seg7_scan_driver;
  localparam int ND = 4;
  localparam int BW = 14;
  localparam int RD = 8;
  localparam int BC = 2;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic [ND-1:0] dp_in    = '0;
  logic          blank_lz = 1'b0;
  logic [7:0]    seg_out;
  logic [ND-1:0] dig_out;
  logic          overflow;

  seg7_scan_driver_if #(.BIN_WIDTH(BW)) bus();

  seg7_scan_driver #(
    .NUM_DIGITS     (ND),
    .BIN_WIDTH      (BW),
    .REFRESH_DIV    (RD),
    .BLANK_CYCLES   (BC),
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b0)
  ) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .bus      (bus),
    .dp_in    (dp_in),
    .blank_lz (blank_lz),
    .seg_out  (seg_out),
    .dig_out  (dig_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [6:0] enc_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int pow10 [ND] = '{1, 10, 100, 1000};

  // Reference model: time since reset, the committed value and a pending conversion.
  int            m_cyc      = 0;
  int            m_val      = 0;
  bit            m_busy     = 1'b0;
  int            m_pend_val = 0;
  int            m_pend_at  = 0;
  logic [7:0]    exp_seg    = 8'hFF;
  logic [ND-1:0] exp_dig    = '0;

  task automatic model_pins(input int c, input int val, input logic [ND-1:0] dp,
                            input logic blz, output logic [7:0] seg, output logic [ND-1:0] dig);
    int slot, idx, digit;
    bit ovf, sup;
    logic [6:0] g;
    slot = c % RD;
    idx  = (c / RD) % ND;
    ovf  = (val > 9999);
    seg  = 8'hFF;
    dig  = '0;
    if (slot >= BC) begin
      digit = (val / pow10[idx]) % 10;
      sup   = blz && !ovf && (idx != 0) && (val < pow10[idx]);
      g     = ovf ? 7'h40 : (sup ? 7'h00 : enc_tbl[digit]);
      seg   = ~{dp[idx], g};
      if (!sup || dp[idx]) dig = ND'(1) << idx;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc   = 0;
      m_val   = 0;
      m_busy  = 1'b0;
      exp_seg = 8'hFF;
      exp_dig = '0;
    end else begin
      bit accept;
      model_pins(m_cyc, m_val, dp_in, blank_lz, exp_seg, exp_dig);
      accept = bus.load && !m_busy;
      m_cyc  = m_cyc + 1;
      if (m_busy && m_cyc == m_pend_at) begin
        m_val  = m_pend_val;
        m_busy = 1'b0;
      end
      if (accept) begin
        m_busy     = 1'b1;
        m_pend_val = int'(bus.value_in);
        m_pend_at  = m_cyc + BW + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("seg_out", 32'(seg_out), 32'(exp_seg));
      chk("dig_out", 32'(dig_out), 32'(exp_dig));
      chk("ready", 32'(bus.ready), 32'(!m_busy));
      chk("overflow", 32'(overflow), 32'(m_val > 9999));
      chk("one_digit", 32'($countones(dig_out) <= 1), 32'd1);
    end
  endtask

  task automatic do_load(input int v);
    bus.value_in = BW'(v);
    bus.load     = 1'b1;
    run(1);
    bus.load     = 1'b0;
  endtask

  initial begin
    int cnt;
    bus.load     = 1'b0;
    bus.value_in = '0;

    // Reset values, then a blank display of 0 across a full scan.
    repeat (3) @(negedge clk);
    chk("rst_seg", 32'(seg_out), 32'hFF);
    chk("rst_dig", 32'(dig_out), 32'h0);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    run(40);

    // 1234: ready low for exactly BIN_WIDTH+1 cycles.
    bus.value_in = BW'(1234);
    bus.load     = 1'b1;
    cnt          = 0;
    for (int i = 0; i < 40; i++) begin
      run(1);
      bus.load = 1'b0;
      if (bus.ready === 1'b0) cnt++;
      else break;
    end
    chk("ready_low_cycles", 32'(cnt), 32'd15);
    run(40);

    // Asynchronous reset in the middle of a conversion.
    do_load(5555);
    run(4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_seg", 32'(seg_out), 32'hFF);
    chk("async_rst_dig", 32'(dig_out), 32'h0);
    chk("async_rst_ready", 32'(bus.ready), 32'd1);
    chk("async_rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(40);

    // Leading-zero suppression, then a dp on a suppressed digit.
    blank_lz = 1'b1;
    do_load(7);
    run(40);
    dp_in = 4'b0100;
    run(40);
    dp_in = 4'b0000;

    // Overflow dashes, then recovery with an in-range value.
    do_load(12000);
    run(40);
    blank_lz = 1'b0;
    do_load(42);
    run(40);

    // Load during SHIFT is dropped; the next one after ready is taken.
    do_load(1111);
    run(5);
    do_load(2222);
    run(45);
    do_load(2222);
    run(40);

    // Boundaries: largest in-range and full-scale input.
    do_load(9999);
    run(40);
    do_load(16383);
    run(40);
    do_load(0);
    run(40);

    // Random loads, decimal points and suppression settings.
    for (int k = 0; k < 25; k++) begin
      dp_in    = ND'($urandom_range(0, 15));
      blank_lz = 1'($urandom_range(0, 1));
      do_load($urandom_range(0, 16383));
      run($urandom_range(10, 50));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
